// File: rtl/frame_buffer_pp.sv
// -----------------------------------------------------------------------------
// frame_buffer_pp
//
// Frame store for a raster pixel stream. A writer FSM accepts pixels in
// raster order, starting at an SOF-qualified pixel. An independent random-
// access read port returns one pixel per request with a one-cycle latency.
//
// Build option (macro FB_DOUBLE_BUF_EN):
//   defined   : two banks. The writer fills bank ~rd_bank while readers see
//               bank rd_bank. The banks swap when the last pixel of a frame
//               is accepted, so a reader never sees a partial frame.
//   undefined : one bank shared by reader and writer. rd_bank is tied to 0.
//               A read and a write to the same address in the same cycle
//               return the old pixel.
//
// Ports
//   clk            in   sole clock, rising edge
//   rst            in   synchronous active-high reset, beats every other input
//   wr_valid       in   pixel strobe (raster order)
//   wr_sof         in   marks the wr_valid pixel as frame pixel (0,0)
//   wr_data        in   pixel value, PIX_W bits
//   wr_frame_done  out  one-cycle pulse in the cycle after the last pixel
//   rd_en          in   read request
//   rd_x, rd_y     in   read column / row
//   rd_data        out  registered read pixel (0 for out-of-range coordinates)
//   rd_valid       out  rd_data is the answer to the previous cycle's rd_en
//   rd_bank        out  bank currently presented to readers
//   err            out  sticky protocol error (pixel without SOF while idle,
//                       or SOF in the middle of a frame)
//
// Pixel memory is not cleared by rst.
// -----------------------------------------------------------------------------
module frame_buffer_pp #(
   parameter int H_RES = 100,
   parameter int V_RES = 100,
   parameter int PIX_W = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_valid,
   input  logic                     wr_sof,
   input  logic [PIX_W-1:0]         wr_data,
   output logic                     wr_frame_done,
   input  logic                     rd_en,
   input  logic [$clog2(H_RES)-1:0] rd_x,
   input  logic [$clog2(V_RES)-1:0] rd_y,
   output logic [PIX_W-1:0]         rd_data,
   output logic                     rd_valid,
   output logic                     rd_bank,
   output logic                     err
);

`ifdef FB_DOUBLE_BUF_EN
   localparam int NBANK = 2;
`else
   localparam int NBANK = 1;
`endif
   localparam int FRAME = H_RES * V_RES;
   localparam int DEPTH = NBANK * FRAME;
   localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   // Internal counters keep at least one bit so a 1-wide raster still works.
   localparam int XW    = (H_RES > 1) ? $clog2(H_RES) : 1;
   localparam int YW    = (V_RES > 1) ? $clog2(V_RES) : 1;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_FILL = 1'b1
   } state_t;

   state_t           r_state;
   state_t           w_state_next;
   logic [XW-1:0]    r_wr_x;
   logic [XW-1:0]    w_wr_x_next;
   logic [XW-1:0]    w_pos_x;
   logic [YW-1:0]    r_wr_y;
   logic [YW-1:0]    w_wr_y_next;
   logic [YW-1:0]    w_pos_y;
   logic             w_wr_en;
   logic             w_err_set;
   logic             w_last;
   logic             r_err;
   logic             r_frame_done;
   logic             r_rd_valid;
   logic [PIX_W-1:0] r_rd_data;
   logic             w_cur_bank;
   logic             w_wr_bank;
   logic             w_rd_in_range;
   logic [AW-1:0]    w_wr_addr;
   logic [AW-1:0]    w_rd_addr;

   logic [PIX_W-1:0] r_mem [DEPTH];

   // ------------------------------------------------------------------
   // Bank selection
   // ------------------------------------------------------------------
`ifdef FB_DOUBLE_BUF_EN
   logic r_rd_bank;

   // Swap on acceptance of the last pixel; the read issued in that same
   // cycle already used the old bank, since w_cur_bank is the registered value.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rd_bank <= 1'b0;
      end else if (w_wr_en && w_last) begin
         r_rd_bank <= ~r_rd_bank;
      end
   end

   assign w_cur_bank = r_rd_bank;
   assign w_wr_bank  = ~r_rd_bank;
`else
   assign w_cur_bank = 1'b0;
   assign w_wr_bank  = 1'b0;
`endif

   // ------------------------------------------------------------------
   // Writer FSM: next state, write strobe and raster counters
   // ------------------------------------------------------------------
   always_comb begin
      w_state_next = r_state;
      w_wr_x_next  = r_wr_x;
      w_wr_y_next  = r_wr_y;
      w_wr_en      = 1'b0;
      w_err_set    = 1'b0;
      w_pos_x      = r_wr_x;
      w_pos_y      = r_wr_y;

      // An SOF pixel always lands at (0,0), whether it starts or restarts a frame.
      if (wr_valid && wr_sof) begin
         w_pos_x = '0;
         w_pos_y = '0;
      end
      w_last = (int'(w_pos_x) == H_RES - 1) && (int'(w_pos_y) == V_RES - 1);

      case (r_state)
         ST_IDLE: begin
            if (wr_valid) begin
               if (wr_sof) begin
                  w_wr_en = 1'b1;
               end else begin
                  w_err_set = 1'b1;   // no frame open: drop the pixel
               end
            end
         end
         ST_FILL: begin
            if (wr_valid) begin
               w_wr_en = 1'b1;
               if (wr_sof) begin
                  w_err_set = 1'b1;   // restart in the same write bank
               end
            end
         end
         default: w_state_next = ST_IDLE;
      endcase

      if (w_wr_en) begin
         if (w_last) begin
            w_state_next = ST_IDLE;
            w_wr_x_next  = '0;
            w_wr_y_next  = '0;
         end else begin
            w_state_next = ST_FILL;
            if (int'(w_pos_x) == H_RES - 1) begin
               w_wr_x_next = '0;
               w_wr_y_next = w_pos_y + 1'b1;
            end else begin
               w_wr_x_next = w_pos_x + 1'b1;
               w_wr_y_next = w_pos_y;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= ST_IDLE;
         r_wr_x       <= '0;
         r_wr_y       <= '0;
         r_err        <= 1'b0;
         r_frame_done <= 1'b0;
      end else begin
         r_state      <= w_state_next;
         r_wr_x       <= w_wr_x_next;
         r_wr_y       <= w_wr_y_next;
         r_err        <= r_err | w_err_set;
         r_frame_done <= w_wr_en & w_last;
      end
   end

   // ------------------------------------------------------------------
   // Pixel memory: one write port, one registered read port
   // ------------------------------------------------------------------
   assign w_wr_addr = AW'(int'(w_wr_bank) * FRAME + int'(w_pos_y) * H_RES + int'(w_pos_x));

   assign w_rd_in_range = (int'(rd_x) < H_RES) && (int'(rd_y) < V_RES);
   // Out-of-range requests are steered to a harmless address; their data is discarded.
   assign w_rd_addr = w_rd_in_range ?
                      AW'(int'(w_cur_bank) * FRAME + int'(rd_y) * H_RES + int'(rd_x)) :
                      '0;

   always_ff @(posedge clk) begin
      if (w_wr_en && !rst) begin
         r_mem[w_wr_addr] <= wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rd_data  <= '0;
         r_rd_valid <= 1'b0;
      end else begin
         r_rd_valid <= rd_en;
         if (rd_en) begin
            r_rd_data <= w_rd_in_range ? r_mem[w_rd_addr] : '0;
         end
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign wr_frame_done = r_frame_done;
   assign rd_data       = r_rd_data;
   assign rd_valid      = r_rd_valid;
   assign rd_bank       = w_cur_bank;
   assign err           = r_err;

endmodule

// File: tb/tb_frame_buffer_pp.sv
// -----------------------------------------------------------------------------
// tb_frame_buffer_pp
//
// Directed bench for frame_buffer_pp at H_RES=4, V_RES=3, PIX_W=1.
// A vector table covers reset, a full 1,0,1,0... frame and a set of reads
// including out-of-range rows; hand-written sequences cover double-buffer
// isolation, SOF protocol errors and reset in the middle of a frame.
// Expected bank and mid-fill read values follow the FB_DOUBLE_BUF_EN build.
// The column port is 2 bits wide for H_RES=4, so every column value is in
// range; rows 3 exercise the out-of-range path.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_frame_buffer_pp;

`ifdef FB_DOUBLE_BUF_EN
   localparam logic DBL = 1'b1;
`else
   localparam logic DBL = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic       wr_valid;
   logic       wr_sof;
   logic [0:0] wr_data;
   logic       wr_frame_done;
   logic       rd_en;
   logic [1:0] rd_x;
   logic [1:0] rd_y;
   logic [0:0] rd_data;
   logic       rd_valid;
   logic       rd_bank;
   logic       err;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   frame_buffer_pp #(
      .H_RES(4),
      .V_RES(3),
      .PIX_W(1)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .wr_valid     (wr_valid),
      .wr_sof       (wr_sof),
      .wr_data      (wr_data),
      .wr_frame_done(wr_frame_done),
      .rd_en        (rd_en),
      .rd_x         (rd_x),
      .rd_y         (rd_y),
      .rd_data      (rd_data),
      .rd_valid     (rd_valid),
      .rd_bank      (rd_bank),
      .err          (err)
   );

   typedef struct {
      logic       r;
      logic       wv;
      logic       s;
      logic       d;
      logic       re;
      logic [1:0] x;
      logic [1:0] y;
      logic       e_done;
      logic       e_rv;
      logic       e_rd;
      logic       e_bank;
      logic       e_err;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input logic r, input logic wv, input logic s, input logic d,
                               input logic re, input logic [1:0] x, input logic [1:0] y,
                               input logic e_done, input logic e_rv, input logic e_rd,
                               input logic e_bank, input logic e_err);
      vec_t v;
      v.r = r; v.wv = wv; v.s = s; v.d = d; v.re = re; v.x = x; v.y = y;
      v.e_done = e_done; v.e_rv = e_rv; v.e_rd = e_rd; v.e_bank = e_bank; v.e_err = e_err;
      return v;
   endfunction

   task automatic chk(input string name, input logic act, input logic exp);
      n_checks++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %b, expected %b", name, act, exp);
      end
   endtask

   // One clock cycle: drive inputs, take the edge, settle 1ns past it.
   task automatic cyc(input logic r, input logic wv, input logic s, input logic d,
                      input logic re, input logic [1:0] x, input logic [1:0] y);
      rst = r; wr_valid = wv; wr_sof = s; wr_data = d; rd_en = re; rd_x = x; rd_y = y;
      @(posedge clk);
      #1;
      $display("t=%0t rst=%b wv=%b sof=%b d=%b re=%b x=%0d y=%0d -> done=%b rv=%b rd=%b bank=%b err=%b",
               $time, r, wv, s, d, re, x, y, wr_frame_done, rd_valid, rd_data, rd_bank, err);
   endtask

   task automatic pix(input logic s, input logic d);
      cyc(1'b0, 1'b1, s, d, 1'b0, 2'd0, 2'd0);
   endtask

   task automatic rd(input logic [1:0] x, input logic [1:0] y);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, x, y);
   endtask

   task automatic do_rst();
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got no $finish, expected end before 100us");
      $fatal(1);
   end

   initial begin
      rst = 1'b0; wr_valid = 1'b0; wr_sof = 1'b0; wr_data = 1'b0;
      rd_en = 1'b0; rd_x = 2'd0; rd_y = 2'd0;

      // ---------------- vector table ----------------
      // reset
      tbl.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0,
                       1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
      // frame 1,0,1,0,... ; done and swap visible after the 12th pixel
      for (int i = 0; i < 12; i++) begin
         tbl.push_back(mk(1'b0, 1'b1, (i == 0), (i % 2 == 0), 1'b0, 2'd0, 2'd0,
                          (i == 11), 1'b0, 1'b0, (i == 11) ? DBL : 1'b0, 1'b0));
      end
      // reads: (x,y) -> data; index = y*4+x, pixel = 1 on even index
      tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 2'd1, 1'b0, 1'b1, 1'b1, DBL, 1'b0));
      tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd3, 1'b0, 1'b1, 1'b0, DBL, 1'b0));
      tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 1'b0, 1'b1, 1'b1, DBL, 1'b0));
      tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 2'd3, 1'b0, 1'b1, 1'b0, DBL, 1'b0));
      tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, DBL, 1'b0));
      tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 2'd0, 1'b0, 1'b1, 1'b1, DBL, 1'b0));
      tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1, DBL, 1'b0));
      tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 2'd0, 1'b0, 1'b1, 1'b0, DBL, 1'b0));
      tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd2, 1'b0, 1'b1, 1'b1, DBL, 1'b0));
      tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 2'd2, 1'b0, 1'b1, 1'b0, DBL, 1'b0));

      foreach (tbl[k]) begin
         cyc(tbl[k].r, tbl[k].wv, tbl[k].s, tbl[k].d, tbl[k].re, tbl[k].x, tbl[k].y);
         chk($sformatf("vec%0d_done", k), wr_frame_done, tbl[k].e_done);
         chk($sformatf("vec%0d_rd_valid", k), rd_valid, tbl[k].e_rv);
         chk($sformatf("vec%0d_rd_data", k), rd_data[0], tbl[k].e_rd);
         chk($sformatf("vec%0d_rd_bank", k), rd_bank, tbl[k].e_bank);
         chk($sformatf("vec%0d_err", k), err, tbl[k].e_err);
      end

      // ---------------- frame A / frame B isolation ----------------
      for (int i = 0; i < 12; i++) begin
         pix((i == 0), 1'b1);
         chk($sformatf("fa_done_px%0d", i), wr_frame_done, (i == 11));
      end
      chk("fa_bank", rd_bank, 1'b0);
      rd(2'd0, 2'd0);
      chk("fa_rd00_valid", rd_valid, 1'b1);
      chk("fa_rd00", rd_data[0], 1'b1);
      for (int i = 0; i < 12; i++) begin
         if (i == 5 || i == 11) begin
            cyc(1'b0, 1'b1, (i == 0), 1'b0, 1'b1, 2'd0, 2'd0);
            chk($sformatf("fb_rd00_valid_px%0d", i), rd_valid, 1'b1);
            chk($sformatf("fb_rd00_midfill_px%0d", i), rd_data[0], DBL);
         end else begin
            pix((i == 0), 1'b0);
         end
         chk($sformatf("fb_done_px%0d", i), wr_frame_done, (i == 11));
      end
      chk("fb_bank", rd_bank, DBL);
      rd(2'd0, 2'd0);
      chk("fb_rd00_after", rd_data[0], 1'b0);

      // ---------------- pixel without SOF after reset ----------------
      do_rst();
      pix(1'b0, 1'b1);
      chk("nosof_err", err, 1'b1);
      chk("nosof_done", wr_frame_done, 1'b0);
      for (int i = 0; i < 12; i++) begin
         pix((i == 0), (i >= 6));
         chk($sformatf("nosof_done_px%0d", i), wr_frame_done, (i == 11));
      end
      chk("nosof_bank", rd_bank, DBL);
      chk("nosof_err_sticky", err, 1'b1);
      rd(2'd1, 2'd1);
      chk("nosof_rd11", rd_data[0], 1'b0);
      rd(2'd2, 2'd1);
      chk("nosof_rd21", rd_data[0], 1'b1);

      // ---------------- SOF in the middle of a frame ----------------
      do_rst();
      for (int i = 0; i < 7; i++) begin
         pix((i == 0), 1'b1);
      end
      chk("midsof_err_before", err, 1'b0);
      pix(1'b1, 1'b0);
      chk("midsof_err", err, 1'b1);
      chk("midsof_done", wr_frame_done, 1'b0);
      chk("midsof_noswap", rd_bank, 1'b0);
      for (int j = 1; j < 12; j++) begin
         pix(1'b0, (j == 11));
         chk($sformatf("midsof_done_px%0d", j), wr_frame_done, (j == 11));
      end
      chk("midsof_bank", rd_bank, DBL);
      rd(2'd0, 2'd0);
      chk("midsof_rd00", rd_data[0], 1'b0);
      rd(2'd2, 2'd1);
      chk("midsof_rd21", rd_data[0], 1'b0);
      rd(2'd3, 2'd2);
      chk("midsof_rd32", rd_data[0], 1'b1);

      // ---------------- reset in the middle of a frame ----------------
      for (int i = 0; i < 6; i++) begin
         pix((i == 0), 1'b1);
      end
      chk("rstmid_done_before", wr_frame_done, 1'b0);
      cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 2'd3, 2'd2);
      chk("rstmid_done", wr_frame_done, 1'b0);
      chk("rstmid_rd_valid", rd_valid, 1'b0);
      chk("rstmid_rd_data", rd_data[0], 1'b0);
      chk("rstmid_bank", rd_bank, 1'b0);
      chk("rstmid_err", err, 1'b0);
      for (int i = 0; i < 12; i++) begin
         pix((i == 0), (i == 3));
         chk($sformatf("rstmid_done_px%0d", i), wr_frame_done, (i == 11));
      end
      chk("rstmid_bank_after", rd_bank, DBL);
      chk("rstmid_err_after", err, 1'b0);
      rd(2'd3, 2'd0);
      chk("rstmid_rd30", rd_data[0], 1'b1);
      rd(2'd0, 2'd0);
      chk("rstmid_rd00", rd_data[0], 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/frame_buffer_pp.md
FRAME_BUFFER_PP -- requirements
Module: frame_buffer_pp

Interface
REQ-001 SHALL have parameter H_RES, default 100, pixels per line.
REQ-002 SHALL have parameter V_RES, default 100, lines per frame.
REQ-003 SHALL have parameter PIX_W, default 1, bits per pixel (1 = black/white).
REQ-004 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port wr_valid  input  1  pixel strobe, raster order.
REQ-007 SHALL have port wr_sof  input  1  qualifies wr_valid pixel as frame pixel (0,0).
REQ-008 SHALL have port wr_data  input  PIX_W  pixel value.
REQ-009 SHALL have port wr_frame_done  output  1  one-cycle pulse, frame complete.
REQ-010 SHALL have port rd_en  input  1  read request.
REQ-011 SHALL have port rd_x  input  $clog2(H_RES)  read column.
REQ-012 SHALL have port rd_y  input  $clog2(V_RES)  read row.
REQ-013 SHALL have port rd_data  output  PIX_W  read pixel, registered.
REQ-014 SHALL have port rd_valid  output  1  rd_data valid.
REQ-015 SHALL have port rd_bank  output  1  bank currently presented to readers.
REQ-016 SHALL have port err  output  1  sticky protocol error flag.

Function
REQ-017 SHALL hold two banks of H_RES*V_RES pixels; writer fills bank ~rd_bank, reader reads bank rd_bank.
REQ-018 SHALL implement writer FSM with states IDLE (await SOF) and FILL.
REQ-019 IDLE: wr_valid&wr_sof writes pixel at (0,0), sets wr_x=1 (or wr_y=1 if H_RES=1), goes to FILL.
REQ-020 IDLE: wr_valid without wr_sof drops the pixel and sets err.
REQ-021 FILL: wr_valid without wr_sof writes at (wr_x,wr_y); wr_x increments, wraps to 0 at H_RES-1 with wr_y+1.
REQ-022 FILL: wr_valid&wr_sof restarts the frame: pixel written at (0,0) of same write bank, counters restart, err set, no swap.
REQ-023 On acceptance of pixel (H_RES-1,V_RES-1): rd_bank toggles and wr_frame_done pulses the next cycle; FSM returns to IDLE; counters clear.
REQ-024 Read latency SHALL be exactly one cycle: rd_data/rd_valid registered from rd_en,rd_x,rd_y sampled at cycle N, valid at N+1.
REQ-025 rd_valid SHALL be 0 in any cycle following rd_en=0; rd_data holds its last value.
REQ-026 Read bank SHALL be rd_bank as sampled in the rd_en cycle; a swap in that same cycle does not affect that read.
REQ-027 rd_x>=H_RES or rd_y>=V_RES SHALL return rd_data=0 with rd_valid=1, and SHALL not set err.
REQ-028 Reader and writer SHALL never access the same bank in the same cycle (double-buffer build).
REQ-029 err SHALL stay 1 until rst.

Reset
REQ-030 rst SHALL force: FSM=IDLE, wr_x=wr_y=0, rd_bank=0, rd_data=0, rd_valid=0, wr_frame_done=0, err=0.
REQ-031 Pixel memory SHALL not be cleared by rst; contents undefined until written.
REQ-032 rst mid-frame SHALL abandon the partial frame without swap; rst has priority over all inputs in its cycle.

Configuration
REQ-033 Macro FB_DOUBLE_BUF_EN defined: two banks, behaviour per REQ-017..REQ-028.
REQ-034 FB_DOUBLE_BUF_EN undefined: single bank, rd_bank tied 0, reads and writes share the bank (read-before-write on same address same cycle), wr_frame_done still pulses per REQ-023.

Verification (H_RES=4, V_RES=3, PIX_W=1 unless stated)
REQ-035 After rst, write 12 pixels pattern 1,0,1,0... with SOF on first -> wr_frame_done pulses once one cycle after 12th pixel, rd_bank 0->1, read (2,1) returns 1 one cycle later.
REQ-036 Write frame A (all 1), read (0,0)=1; start frame B (all 0) and read (0,0) mid-fill -> still 1 until B completes, then 0.
REQ-037 wr_valid without SOF after reset -> pixel dropped, err=1, no wr_frame_done; subsequent valid SOF frame still completes normally.
REQ-038 SOF asserted at pixel 7 of a frame -> err=1, no swap, following 12 pixels complete the frame and swap once.
REQ-039 Read (4,0) and (0,3) -> rd_data=0, rd_valid=1, err unchanged; rd_en=0 next cycle -> rd_valid=0.
REQ-040 rst asserted after 6 pixels -> all outputs zero next cycle, rd_bank=0, no wr_frame_done; new full frame then swaps to bank 1.
